// File: rtl/duel_reaction_ctrl.sv
// Two-player reaction-duel controller: random foreperiod, go lamp, stop-button
// arbitration with false-start detection, per-player scoring and match end.
module duel_reaction_ctrl #(
  parameter int unsigned MIN_DELAY     = 100000000,
  parameter int unsigned SPAN          = 200000000,
  parameter int unsigned DELAY_BITS    = 28,
  parameter int unsigned TIMEOUT       = 500000000,
  parameter int unsigned ROUNDS_TO_WIN = 3
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       start,
  input  logic       stop_a,
  input  logic       stop_b,
  output logic [1:0] CounterFlag,
  output logic       LED,
  output logic       ErrorFlag_A,
  output logic       ErrorFlag_B,
  output logic [1:0] winner,
  output logic [1:0] score_a,
  output logic [1:0] score_b,
  output logic       match_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_GO,
    S_RESULT,
    S_MATCH_END
  } state_t;

  localparam logic [31:0] MIN_DELAY_W = 32'(MIN_DELAY);
  localparam logic [31:0] SPAN_W      = 32'(SPAN);
  localparam logic [31:0] TIMEOUT_W   = 32'(TIMEOUT);
  localparam logic [1:0]  WIN_SCORE   = 2'(ROUNDS_TO_WIN);
  localparam logic [31:0] LFSR_SEED   = 32'hACE10001;
  localparam logic [31:0] LFSR_TAPS   = 32'h80200003;
  localparam logic [31:0] OFFSET_MASK = (DELAY_BITS >= 32) ? 32'hFFFF_FFFF
                                        : ((32'd1 << DELAY_BITS) - 32'd1);

  logic [3:0]  w_pins;
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_prev;
  logic [3:0]  w_event;
  logic        w_clearEv;
  logic        w_startEv;
  logic        w_stopA;
  logic        w_stopB;

  logic [31:0] r_lfsr;
  logic [31:0] w_lfsrNext;
  logic [31:0] w_offsetRaw;
  logic [31:0] w_offset;
  logic [31:0] w_delay;

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_cnt;
  logic [31:0] w_cntNext;
  logic [31:0] r_delay;
  logic [31:0] w_delayNext;
  logic [1:0]  r_winner;
  logic [1:0]  w_winnerNext;
  logic        r_errA;
  logic        w_errANext;
  logic        r_errB;
  logic        w_errBNext;
  logic [1:0]  r_scoreA;
  logic [1:0]  w_scoreANext;
  logic [1:0]  r_scoreB;
  logic [1:0]  w_scoreBNext;
  logic        r_matchOver;
  logic        w_matchOverNext;
  logic        w_launch;

  function automatic logic [1:0] satInc(input logic [1:0] s);
    return (s >= WIN_SCORE) ? s : s + 2'd1;
  endfunction

  assign w_pins    = {stop_b, stop_a, start, clear};
  assign w_event   = r_sync2 & ~r_prev;
  assign w_clearEv = w_event[0];
  assign w_startEv = w_event[1];
  assign w_stopA   = w_event[2];
  assign w_stopB   = w_event[3];

  // Two-flop synchronizer plus one history flop for rising-edge detection.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= w_pins;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_lfsrNext  = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
  assign w_offsetRaw = r_lfsr & OFFSET_MASK;
  // SPAN exceeds half the offset range, so one subtraction folds it into range.
  assign w_offset    = (w_offsetRaw >= SPAN_W) ? (w_offsetRaw - SPAN_W) : w_offsetRaw;
  assign w_delay     = MIN_DELAY_W + w_offset;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr      <= LFSR_SEED;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_delay     <= '0;
      r_winner    <= '0;
      r_errA      <= 1'b0;
      r_errB      <= 1'b0;
      r_scoreA    <= '0;
      r_scoreB    <= '0;
      r_matchOver <= 1'b0;
    end else begin
      r_lfsr      <= w_lfsrNext;
      r_state     <= w_stateNext;
      r_cnt       <= w_cntNext;
      r_delay     <= w_delayNext;
      r_winner    <= w_winnerNext;
      r_errA      <= w_errANext;
      r_errB      <= w_errBNext;
      r_scoreA    <= w_scoreANext;
      r_scoreB    <= w_scoreBNext;
      r_matchOver <= w_matchOverNext;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_cntNext       = r_cnt;
    w_delayNext     = r_delay;
    w_winnerNext    = r_winner;
    w_errANext      = r_errA;
    w_errBNext      = r_errB;
    w_scoreANext    = r_scoreA;
    w_scoreBNext    = r_scoreB;
    w_matchOverNext = r_matchOver;
    w_launch        = 1'b0;

    if (w_clearEv) begin
      w_stateNext     = S_IDLE;
      w_cntNext       = '0;
      w_winnerNext    = 2'b00;
      w_errANext      = 1'b0;
      w_errBNext      = 1'b0;
      w_scoreANext    = 2'b00;
      w_scoreBNext    = 2'b00;
      w_matchOverNext = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: w_launch = w_startEv;
        S_WAIT: begin
          w_cntNext = r_cnt + 32'd1;
          if (w_stopA || w_stopB) begin
            w_stateNext = S_RESULT;
            w_cntNext   = '0;
            w_errANext  = w_stopA;
            w_errBNext  = w_stopB;
            case ({w_stopB, w_stopA})
              2'b01: begin
                w_winnerNext = 2'b10;
                w_scoreBNext = satInc(r_scoreB);
              end
              2'b10: begin
                w_winnerNext = 2'b01;
                w_scoreANext = satInc(r_scoreA);
              end
              default: w_winnerNext = 2'b00;
            endcase
          end else if (r_cnt == r_delay - 32'd1) begin
            w_stateNext = S_GO;
            w_cntNext   = '0;
          end
        end
        S_GO: begin
          w_cntNext = r_cnt + 32'd1;
          if (w_stopA || w_stopB) begin
            w_stateNext = S_RESULT;
            w_cntNext   = '0;
            case ({w_stopB, w_stopA})
              2'b01: begin
                w_winnerNext = 2'b01;
                w_scoreANext = satInc(r_scoreA);
              end
              2'b10: begin
                w_winnerNext = 2'b10;
                w_scoreBNext = satInc(r_scoreB);
              end
              default: w_winnerNext = 2'b11;
            endcase
          end else if (r_cnt == TIMEOUT_W - 32'd1) begin
            w_stateNext  = S_RESULT;
            w_cntNext    = '0;
            w_winnerNext = 2'b00;
          end
        end
        S_RESULT: begin
          if (r_scoreA == WIN_SCORE || r_scoreB == WIN_SCORE) begin
            w_stateNext     = S_MATCH_END;
            w_matchOverNext = 1'b1;
          end else begin
            w_launch = w_startEv;
          end
        end
        S_MATCH_END: w_stateNext = S_MATCH_END;
        default:     w_stateNext = S_IDLE;
      endcase

      if (w_launch) begin
        w_stateNext  = S_WAIT;
        w_cntNext    = '0;
        w_delayNext  = w_delay;
        w_winnerNext = 2'b00;
        w_errANext   = 1'b0;
        w_errBNext   = 1'b0;
      end
    end
  end

  // Lamp and display-timer control decode straight from the state.
  always_comb begin
    LED         = 1'b0;
    CounterFlag = 2'b00;
    case (r_state)
      S_GO:                  begin LED = 1'b1; CounterFlag = 2'b10; end
      S_RESULT, S_MATCH_END: CounterFlag = 2'b01;
      default:               CounterFlag = 2'b00;
    endcase
  end

  assign ErrorFlag_A = r_errA;
  assign ErrorFlag_B = r_errB;
  assign winner      = r_winner;
  assign score_a     = r_scoreA;
  assign score_b     = r_scoreB;
  assign match_over  = r_matchOver;

endmodule

// File: tb/tb_duel_reaction_ctrl.sv
// Self-checking bench for duel_reaction_ctrl: constant vector table, directed
// round sequences and randomized button traffic against a timestamp-based model.
`timescale 1ns/1ps
module tb_duel_reaction_ctrl;

  localparam int MIN_DELAY     = 5;
  localparam int SPAN          = 10;
  localparam int DELAY_BITS    = 4;
  localparam int TIMEOUT       = 50;
  localparam int ROUNDS_TO_WIN = 2;

  localparam logic [3:0] NONE   = 4'b0000;
  localparam logic [3:0] CLEAR  = 4'b0001;
  localparam logic [3:0] START  = 4'b0010;
  localparam logic [3:0] STOP_A = 4'b0100;
  localparam logic [3:0] STOP_B = 4'b1000;

  localparam int P_IDLE = 0, P_WAIT = 1, P_GO = 2, P_RESULT = 3, P_MATCH = 4;

  logic       clk_50M = 1'b0;
  logic       rst_n;
  logic       clear, start, stop_a, stop_b;
  logic [1:0] CounterFlag;
  logic       LED;
  logic       ErrorFlag_A, ErrorFlag_B;
  logic [1:0] winner, score_a, score_b;
  logic       match_over;
  logic [11:0] dutOut;

  int nTests = 0;
  int nFail  = 0;

  // Model state: round phase plus absolute cycle stamps for go and void.
  int          mPhase, mCycle, mGoAt, mVoidAt, mDelay;
  int          mScoreA, mScoreB, mWinner;
  bit          mErrA, mErrB, mMatch;
  logic [31:0] mLfsr;
  logic [3:0]  mLastPin, mRise1, mRise2;

  typedef struct {
    logic [3:0]  pins;
    logic [11:0] expOut;
  } vec_t;
  vec_t vecs[10];

  always #10 clk_50M = ~clk_50M;

  duel_reaction_ctrl #(
    .MIN_DELAY(MIN_DELAY), .SPAN(SPAN), .DELAY_BITS(DELAY_BITS),
    .TIMEOUT(TIMEOUT), .ROUNDS_TO_WIN(ROUNDS_TO_WIN)
  ) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .clear(clear), .start(start),
    .stop_a(stop_a), .stop_b(stop_b), .CounterFlag(CounterFlag), .LED(LED),
    .ErrorFlag_A(ErrorFlag_A), .ErrorFlag_B(ErrorFlag_B), .winner(winner),
    .score_a(score_a), .score_b(score_b), .match_over(match_over)
  );

  assign dutOut = {CounterFlag, LED, ErrorFlag_A, ErrorFlag_B, winner, score_a, score_b, match_over};

  function automatic logic [31:0] lfsrNext(input logic [31:0] v);
    logic [31:0] s;
    s = v >> 1;
    if (v[0]) s = s ^ 32'h80200003;
    return s;
  endfunction

  function automatic int incSat(input int s);
    return (s + 1 > ROUNDS_TO_WIN) ? ROUNDS_TO_WIN : s + 1;
  endfunction

  function automatic logic [11:0] modelOut();
    logic [1:0] cf;
    cf = (mPhase == P_GO) ? 2'b10 : (mPhase >= P_RESULT) ? 2'b01 : 2'b00;
    return {cf, mPhase == P_GO, mErrA, mErrB, 2'(mWinner), 2'(mScoreA), 2'(mScoreB), mMatch};
  endfunction

  task automatic resetModel();
    mPhase = P_IDLE; mCycle = 0; mGoAt = 0; mVoidAt = 0; mDelay = 0;
    mScoreA = 0; mScoreB = 0; mWinner = 0;
    mErrA = 0; mErrB = 0; mMatch = 0;
    mLfsr = 32'hACE10001;
    mLastPin = '0; mRise1 = '0; mRise2 = '0;
  endtask

  task automatic beginRound();
    int r;
    r = int'(mLfsr % (32'd1 << DELAY_BITS));
    if (r >= SPAN) r = r - SPAN;
    mDelay  = MIN_DELAY + r;
    mGoAt   = mCycle + mDelay;
    mPhase  = P_WAIT;
    mWinner = 0; mErrA = 0; mErrB = 0;
  endtask

  // A pin rise seen at one clock edge takes effect two edges later.
  task automatic modelEdge(input logic [3:0] pins);
    logic [3:0] ev;
    ev       = mRise2;
    mRise2   = mRise1;
    mRise1   = pins & ~mLastPin;
    mLastPin = pins;
    mCycle++;
    if (ev[0]) begin
      mPhase = P_IDLE; mScoreA = 0; mScoreB = 0; mWinner = 0;
      mErrA = 0; mErrB = 0; mMatch = 0;
    end else begin
      case (mPhase)
        P_IDLE: if (ev[1]) beginRound();
        P_WAIT: begin
          if (ev[2] || ev[3]) begin
            mPhase = P_RESULT;
            mErrA = ev[2]; mErrB = ev[3];
            if (ev[2] && ev[3]) mWinner = 0;
            else if (ev[2]) begin mWinner = 2; mScoreB = incSat(mScoreB); end
            else begin mWinner = 1; mScoreA = incSat(mScoreA); end
          end else if (mCycle == mGoAt) begin
            mPhase  = P_GO;
            mVoidAt = mCycle + TIMEOUT;
          end
        end
        P_GO: begin
          if (ev[2] || ev[3]) begin
            mPhase = P_RESULT;
            if (ev[2] && ev[3]) mWinner = 3;
            else if (ev[2]) begin mWinner = 1; mScoreA = incSat(mScoreA); end
            else begin mWinner = 2; mScoreB = incSat(mScoreB); end
          end else if (mCycle == mVoidAt) begin
            mPhase = P_RESULT; mWinner = 0;
          end
        end
        P_RESULT: begin
          if (mScoreA == ROUNDS_TO_WIN || mScoreB == ROUNDS_TO_WIN) begin
            mPhase = P_MATCH; mMatch = 1;
          end else if (ev[1]) beginRound();
        end
        default: ;
      endcase
    end
    mLfsr = lfsrNext(mLfsr);
  endtask

  task automatic checkOutput(input string name, input logic [11:0] expected);
    nTests++;
    if (dutOut !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %b, expected %b", name, dutOut, expected);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    nTests++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Called at a falling edge: drive pins, clock once, check against the model.
  task automatic applyStimulus(input logic [3:0] pins);
    {stop_b, stop_a, start, clear} = pins;
    @(posedge clk_50M);
    modelEdge(pins);
    @(negedge clk_50M);
    checkOutput($sformatf("model cycle %0d", mCycle), modelOut());
  endtask

  task automatic launchRound();
    applyStimulus(START);
    applyStimulus(NONE);
    applyStimulus(NONE);
  endtask

  task automatic waitLed(input string name, input int expected);
    int n;
    n = 0;
    while (LED !== 1'b1 && n < 200) begin
      applyStimulus(NONE);
      n++;
    end
    checkValue(name, n, expected);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    {stop_b, stop_a, start, clear} = NONE;
    rst_n = 1'b0;
    resetModel();
    repeat (3) @(negedge clk_50M);
    checkOutput("reset state", 12'b0);
    rst_n = 1'b1;

    repeat (20) applyStimulus(NONE);
    checkOutput("idle", 12'b0);

    // False start by A one cycle after entering WAIT.
    vecs[0] = '{NONE,   12'b0};
    vecs[1] = '{NONE,   12'b0};
    vecs[2] = '{NONE,   12'b0};
    vecs[3] = '{START,  12'b0};
    vecs[4] = '{STOP_A, 12'b0};
    vecs[5] = '{NONE,   12'b0};
    vecs[6] = '{NONE,   12'b01_0_1_0_10_00_01_0};
    vecs[7] = '{NONE,   12'b01_0_1_0_10_00_01_0};
    vecs[8] = '{START,  12'b01_0_1_0_10_00_01_0};
    vecs[9] = '{NONE,   12'b01_0_1_0_10_00_01_0};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].pins);
      checkOutput($sformatf("vector %0d", i), vecs[i].expOut);
    end

    // B wins a clean round, reaching the match score.
    launchRound();
    waitLed("go delay B round", mDelay);
    checkValue("go counterflag", int'(CounterFlag), 2);
    repeat (4) applyStimulus(NONE);
    applyStimulus(STOP_B);
    applyStimulus(NONE);
    checkValue("led held before press", int'(LED), 1);
    applyStimulus(NONE);
    checkOutput("b wins", 12'b01_0_0_0_10_00_10_0);
    applyStimulus(NONE);
    checkOutput("match over", 12'b01_0_0_0_10_00_10_1);
    applyStimulus(START);
    repeat (5) applyStimulus(NONE);
    checkOutput("start ignored", 12'b01_0_0_0_10_00_10_1);

    // Clear, then a simultaneous press during GO.
    applyStimulus(CLEAR);
    applyStimulus(NONE);
    applyStimulus(NONE);
    checkOutput("clear", 12'b0);
    launchRound();
    waitLed("go delay tie round", mDelay);
    repeat (2) applyStimulus(NONE);
    applyStimulus(STOP_A | STOP_B);
    applyStimulus(NONE);
    applyStimulus(NONE);
    checkOutput("tie", 12'b01_0_0_0_11_00_00_0);

    // No press: round voided after TIMEOUT cycles of GO.
    launchRound();
    waitLed("go delay void round", mDelay);
    repeat (TIMEOUT - 1) applyStimulus(NONE);
    checkValue("led before timeout", int'(LED), 1);
    applyStimulus(NONE);
    checkOutput("timeout", 12'b01_0_0_0_00_00_00_0);

    // Asynchronous reset in the middle of GO.
    launchRound();
    waitLed("go delay reset round", mDelay);
    repeat (3) applyStimulus(NONE);
    @(posedge clk_50M);
    #3;
    rst_n = 1'b0;
    #1;
    checkValue("async reset LED", int'(LED), 0);
    checkValue("async reset counterflag", int'(CounterFlag), 0);
    resetModel();
    @(negedge clk_50M);
    checkOutput("held in reset", 12'b0);
    @(negedge clk_50M);
    rst_n = 1'b1;
    launchRound();
    waitLed("go delay after reseed", mDelay);

    // Randomized button traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] p;
      p[0] = ($urandom_range(0, 149) == 0);
      p[1] = ($urandom_range(0, 5) == 0);
      p[2] = ($urandom_range(0, 24) == 0);
      p[3] = ($urandom_range(0, 24) == 0);
      applyStimulus(p);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
